// File: rtl/mitchell_div16_pipe_if.sv
`default_nettype none
// ============================================================================
//  Module      : mitchell_div16_pipe_if
//  Description : Operand/result stream bundle for the Mitchell divider.
//                The slave side is the divider, the master side its client.
//  Revision    : 1.0  initial release
// ============================================================================
interface mitchell_div16_pipe_if;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [23:0] q;
    logic        div_by_zero;

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, q, div_by_zero
    );

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, q, div_by_zero
    );
endinterface
`default_nettype wire

// File: rtl/mitchell_div16_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : mitchell_div16_pipe
//  Description : Three-stage approximate 16-bit unsigned divider based on the
//                Mitchell logarithm: leading-one/mantissa extraction, log
//                subtraction, piecewise-linear antilog into Q16.8.
//                Optional macro MITCHELL_DIV_ROUND_EN selects round-half-up
//                on right shifts instead of truncation.
//  Revision    : 1.0  initial release
// ============================================================================
module mitchell_div16_pipe #(
    parameter int FRAC_W   = 15,
    parameter int OUT_FRAC = 8
) (
    input  wire logic              clk,
    input  wire logic              rst,
    mitchell_div16_pipe_if.slave   bus
);

    // Whole pipeline moves in lockstep whenever the output slot is free
    logic w_advance;
    assign w_advance    = !bus.out_valid || bus.out_ready;
    assign bus.in_ready = w_advance;

    // Position of the most significant set bit (0 for a zero operand)
    function automatic logic [3:0] lead_one(input logic [15:0] v);
        logic [3:0] k;
        k = '0;
        for (int i = 0; i < 16; i++) begin
            if (v[i]) k = 4'(i);
        end
        return k;
    endfunction

    // ------------------------------------------------------------------
    // Stage 1: logarithm (characteristic + fractional mantissa)
    // ------------------------------------------------------------------
    logic        v1_q;
    logic [3:0]  ka1_q, kb1_q, ka1_d, kb1_d;
    logic [14:0] xa1_q, xb1_q, xa1_d, xb1_d;
    logic        za1_q, zb1_q;
    logic [15:0] w_a_norm, w_b_norm;

    // Normalise each operand so its leading one sits at bit 15
    always_comb begin
        ka1_d    = lead_one(bus.a);
        kb1_d    = lead_one(bus.b);
        w_a_norm = bus.a << (4'd15 - ka1_d);
        w_b_norm = bus.b << (4'd15 - kb1_d);
        xa1_d    = w_a_norm[FRAC_W-1:0];
        xb1_d    = w_b_norm[FRAC_W-1:0];
    end

    // Stage 1 register: valid follows acceptance, data loads on acceptance
    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q  <= 1'b0;
            ka1_q <= '0;
            kb1_q <= '0;
            xa1_q <= '0;
            xb1_q <= '0;
            za1_q <= 1'b0;
            zb1_q <= 1'b0;
        end else if (w_advance) begin
            v1_q <= bus.in_valid;
            if (bus.in_valid) begin
                ka1_q <= ka1_d;
                kb1_q <= kb1_d;
                xa1_q <= xa1_d;
                xb1_q <= xb1_d;
                za1_q <= (bus.a == 16'd0);
                zb1_q <= (bus.b == 16'd0);
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: log subtraction with borrow into the characteristic
    // ------------------------------------------------------------------
    logic               v2_q;
    logic [15:0]        m2_q, m2_d;
    logic signed [5:0]  e2_q, e2_d;
    logic               za2_q, zb2_q;

    // Mantissa difference; a borrow moves one unit from the exponent
    always_comb begin
        e2_d = 6'($signed({2'b00, ka1_q}) - $signed({2'b00, kb1_q}));
        if (xa1_q >= xb1_q) begin
            m2_d = {1'b1, xa1_q - xb1_q};
        end else begin
            m2_d = 16'(17'h10000 + {2'b00, xa1_q} - {2'b00, xb1_q});
            e2_d = e2_d - 6'sd1;
        end
    end

    // Stage 2 register
    always_ff @(posedge clk) begin
        if (rst) begin
            v2_q  <= 1'b0;
            m2_q  <= '0;
            e2_q  <= '0;
            za2_q <= 1'b0;
            zb2_q <= 1'b0;
        end else if (w_advance) begin
            v2_q <= v1_q;
            if (v1_q) begin
                m2_q  <= m2_d;
                e2_q  <= e2_d;
                za2_q <= za1_q;
                zb2_q <= zb1_q;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 3: antilog into Q16.8, special-case override
    // ------------------------------------------------------------------
    logic               v3_q;
    logic [23:0]        quot_q, quot_d;
    logic               dbz_q, dbz_d;
    logic signed [5:0]  w_s;
    logic [5:0]         w_neg_s;
    logic [4:0]         w_rsh;
    logic [23:0]        w_m_ext;

    // m carries 15 fraction bits; the output has OUT_FRAC, hence e-7
    always_comb begin
        w_s     = e2_q - 6'(FRAC_W - OUT_FRAC);
        w_neg_s = 6'(-w_s);
        w_rsh   = w_neg_s[4:0];
        w_m_ext = {8'd0, m2_q};
        dbz_d   = 1'b0;
        if (!w_s[5]) begin
            quot_d = w_m_ext << w_s[3:0];
        end else begin
`ifdef MITCHELL_DIV_ROUND_EN
            quot_d = (w_m_ext + (24'd1 << (w_rsh - 5'd1))) >> w_rsh;
`else
            quot_d = w_m_ext >> w_rsh;
`endif
        end
        if (zb2_q) begin
            quot_d = 24'hFFFFFF;
            dbz_d  = 1'b1;
        end else if (za2_q) begin
            quot_d = 24'd0;
        end
    end

    // Output register: only a valid stage-2 result may overwrite q
    always_ff @(posedge clk) begin
        if (rst) begin
            v3_q   <= 1'b0;
            quot_q <= '0;
            dbz_q  <= 1'b0;
        end else if (w_advance) begin
            v3_q <= v2_q;
            if (v2_q) begin
                quot_q <= quot_d;
                dbz_q  <= dbz_d;
            end
        end
    end

    assign bus.out_valid   = v3_q;
    assign bus.q           = quot_q;
    assign bus.div_by_zero = dbz_q;

endmodule
`default_nettype wire

// File: tb/tb_mitchell_div16_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mitchell_div16_pipe
//  Description : Directed bench for the Mitchell divider with hand-computed
//                quotients, backpressure and mid-flight reset scenarios.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mitchell_div16_pipe;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;

    mitchell_div16_pipe_if bus();

    mitchell_div16_pipe dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef MITCHELL_DIV_ROUND_EN
    localparam logic [23:0] c_ONE_OVER_384 = 24'h000001;
`else
    localparam logic [23:0] c_ONE_OVER_384 = 24'h000000;
`endif

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One isolated operation: latency exactly 3 cycles, then check result
    task automatic single(input logic [15:0] a, input logic [15:0] b,
                          input logic [23:0] exp_q, input logic exp_dbz);
        bus.a        = a;
        bus.b        = b;
        bus.in_valid = 1'b1;
        check("single_in_ready", 32'(bus.in_ready), 32'd1);
        tick();
        bus.in_valid = 1'b0;
        check("single_lat_c1", 32'(bus.out_valid), 32'd0);
        tick();
        check("single_lat_c2", 32'(bus.out_valid), 32'd0);
        tick();
        check("single_valid", 32'(bus.out_valid), 32'd1);
        check("single_q", 32'(bus.q), 32'(exp_q));
        check("single_dbz", 32'(bus.div_by_zero), 32'(exp_dbz));
        tick();
        check("single_drained", 32'(bus.out_valid), 32'd0);
    endtask

    initial begin
        n_cmp         = 0;
        n_bad         = 0;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.out_ready = 1'b1;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_q", 32'(bus.q), 32'd0);
        check("rst_dbz", 32'(bus.div_by_zero), 32'd0);
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);

        // Directed quotients
        single(16'd100,  16'd10,    24'h000A80, 1'b0);
        single(16'd10,   16'd100,   24'h00001B, 1'b0);
        single(16'h8000, 16'd1,     24'h800000, 1'b0);
        single(16'h1234, 16'd0,     24'hFFFFFF, 1'b1);
        single(16'd0,    16'd7,     24'h000000, 1'b0);
        single(16'd1,    16'h0180,  c_ONE_OVER_384, 1'b0);
        single(16'd7,    16'd7,     24'h000100, 1'b0);
        single(16'd0,    16'd0,     24'hFFFFFF, 1'b1);
        single(16'hFFFF, 16'hFFFF,  24'h000100, 1'b0);
        single(16'hFFFF, 16'd1,     24'hFFFF00, 1'b0);
        single(16'd1,    16'hFFFF,  24'h000000, 1'b0);

        // Backpressure: four pairs offered with the consumer stalled
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.a = 16'd100;   bus.b = 16'd10;
        check("bp_rdy0", 32'(bus.in_ready), 32'd1);
        tick();
        bus.a = 16'd10;    bus.b = 16'd100;
        check("bp_rdy1", 32'(bus.in_ready), 32'd1);
        tick();
        bus.a = 16'd7;     bus.b = 16'd7;
        check("bp_rdy2", 32'(bus.in_ready), 32'd1);
        tick();
        bus.a = 16'hFFFF;  bus.b = 16'd1;
        check("bp_rdy3_blocked", 32'(bus.in_ready), 32'd0);
        check("bp_head_valid", 32'(bus.out_valid), 32'd1);
        check("bp_head_q", 32'(bus.q), 32'h000A80);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("bp_stall_ready", 32'(bus.in_ready), 32'd0);
            check("bp_stall_valid", 32'(bus.out_valid), 32'd1);
            check("bp_stall_q", 32'(bus.q), 32'h000A80);
        end
        // Release: fourth pair enters as the head drains
        bus.out_ready = 1'b1;
        #1;
        check("bp_release_ready", 32'(bus.in_ready), 32'd1);
        tick();
        bus.in_valid = 1'b0;
        check("bp_d1_valid", 32'(bus.out_valid), 32'd1);
        check("bp_d1_q", 32'(bus.q), 32'h00001B);
        tick();
        check("bp_d2_valid", 32'(bus.out_valid), 32'd1);
        check("bp_d2_q", 32'(bus.q), 32'h000100);
        tick();
        check("bp_d3_valid", 32'(bus.out_valid), 32'd1);
        check("bp_d3_q", 32'(bus.q), 32'hFFFF00);
        tick();
        check("bp_empty", 32'(bus.out_valid), 32'd0);

        // Reset with two operations in flight
        bus.in_valid = 1'b1;
        bus.a = 16'd100;  bus.b = 16'd10;
        tick();
        bus.a = 16'd10;   bus.b = 16'd100;
        tick();
        bus.in_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mrst_in_ready", 32'(bus.in_ready), 32'd1);
        for (int i = 0; i < 4; i++) begin
            check("mrst_no_output", 32'(bus.out_valid), 32'd0);
            tick();
        end
        single(16'h8000, 16'd1, 24'h800000, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
